sha256d_header_ctrl: RTL and testbench
======================================

# sha256d_header_ctrl

Bus-master sequencer that computes the Bitcoin double SHA-256 (SHA-256d) of an 80-byte block header by driving the register interface of the `sha256` wrapper. It sits directly upstream of `sha256` in the mining datapath. It accepts a header and a start pulse from the nonce/job logic, writes padded message blocks, issues init/next commands, polls status and reads digests. It returns the final 256-bit hash with a one-cycle done pulse.

## Interface
- `SETTLE_CYCLES`, 4: idle cycles after each CTRL write before status polling begins; covers the registered `ready` lag in `sha256`; range 1..15.
- `TIMEOUT_CYCLES`, 1023: maximum consecutive poll cycles before the job is aborted; range 1..65535.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  job request; sampled only in IDLE.
- `header`  in  640  header bytes, byte 0 at bits [639:632]; word k = `header[639-32k -: 32]`.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse; `hash` valid.
- `error`  out  1  one-cycle pulse on poll timeout.
- `hash`  out  256  SHA-256d result, first digest word at [255:224].
- `sha_cs`  out  1  to `sha256.cs`.
- `sha_we`  out  1  to `sha256.we`.
- `sha_address`  out  8  to `sha256.address`.
- `sha_write_data`  out  32  to `sha256.write_data`.
- `sha_read_data`  in  32  from `sha256.read_data`; combinational in the same cycle as the read.

## Operation
- Register map used: 0x08 CTRL (bit0 init, bit1 next, bit2 mode); 0x09 STATUS (bit0 ready, bit1 valid); 0x10–0x1F block words 0–15; 0x20–0x27 digest words 0–7.
- `start` in IDLE latches `header` into an internal register. Later `header` changes have no effect. `start` while busy is ignored.
- States: IDLE → PRE_POLL → {WR_BLK → WR_CTRL → SETTLE → POLL → [RD_DIG]} × 3 phases → DONE → IDLE.
- PRE_POLL: read STATUS until bit0 = 1. This guarantees the core is idle, including after this block alone has been reset.
- WR_BLK: 16 consecutive write cycles with `sha_cs`=1, `sha_we`=1, address 0x10+i, i = 0..15.
  - Phase 0: W[i] = header word i. CTRL = 0x5 (init, SHA-256 mode).
  - Phase 1: W0–W3 = header words 16–19; W4 = 0x80000000; W5–W14 = 0; W15 = 0x00000280. CTRL = 0x6 (next).
  - Phase 2: W0–W7 = mid digest D0–D7; W8 = 0x80000000; W9–W14 = 0; W15 = 0x00000100. CTRL = 0x5 (init).
- WR_CTRL: one write cycle to 0x08.
- SETTLE: `SETTLE_CYCLES` cycles with `sha_cs`=0.
- POLL: read 0x09 each cycle. Exit when `sha_read_data[1:0]` = 2'b11.
- RD_DIG: 8 read cycles at 0x20..0x27.
  - Not executed after phase 0.
  - After phase 1: capture into the mid-digest register.
  - After phase 2: capture into `hash`.
- Timeout: a 16-bit counter counts consecutive PRE_POLL/POLL cycles. If it reaches `TIMEOUT_CYCLES` without an exit condition, pulse `error` and go to IDLE. `hash` is unchanged.
- Bus outputs are driven from state registers only; there is no combinational path from any input to `sha_*`.
- In every non-bus cycle (IDLE, SETTLE, DONE): `sha_cs`=0, `sha_we`=0, `sha_address`=0, `sha_write_data`=0.

## Timing
- Reset values, one edge after `reset_n`=0: `busy`=0, `done`=0, `error`=0, `hash`=0, all `sha_*` outputs 0, state IDLE, counters 0, latched header and mid digest 0.
- Reset mid-job: the job is abandoned with no `done` or `error`. The next job re-synchronises through PRE_POLL.
- `busy` rises the edge after `start` is sampled. It falls on the same edge that `done` or `error` rises.
- `sha_read_data` is sampled on the edge that ends the cycle in which `sha_cs`=1 and `sha_we`=0.
- `hash` updates on the same edge `done` rises and holds until the next successful job.
- Latency, start to done: 1 + P0 + 3×(16 + 1 + `SETTLE_CYCLES` + Pk) + 16 + 1 cycles, where Pk is the number of poll cycles in each phase (each ≥ 1).
- A new `start` is accepted in the cycle after `done` or `error`, i.e. once back in IDLE.

## Test plan
- Genesis header `0100…00 3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a 29ab5f49 ffff001d 1dac2b7c`, with real `sha256` attached → `done` pulse once; `hash` = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000.
- Bus monitor on the same job:
  - CTRL write data sequence exactly 0x5, 0x6, 0x5.
  - Phase 1 writes 0x80000000 to 0x14 and 0x00000280 to 0x1F.
  - Phase 2 writes 0x80000000 to 0x18 and 0x00000100 to 0x1F.
  - Exactly 16 digest reads in total.
- Stub slave with STATUS stuck at 0, `TIMEOUT_CYCLES`=8 → `error` pulses after 8 PRE_POLL cycles; `busy` falls on the same edge; `hash` still 0; `done` never asserted.
- `start` pulsed again mid-job with a different header → ignored; result equals the first header's hash. A third `start` one cycle after `done` is accepted.
- `reset_n`=0 for one cycle during phase 1 WR_BLK → all outputs 0 next edge. A following job with the genesis header produces the correct hash.
- `header` input changed on the cycle after `start` → result still equals the latched header's hash.

Source files
------------

// File: rtl/sha256d_header_ctrl.sv
// Sequencer that drives a sha256 register-interface core to compute SHA-256d of an 80-byte header.
// Three compression passes: header block 0, padded header tail, then the padded mid digest.
module sha256d_header_ctrl #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [639:0] header,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [255:0] hash,
  output logic         sha_cs,
  output logic         sha_we,
  output logic [7:0]   sha_address,
  output logic [31:0]  sha_write_data,
  input  logic [31:0]  sha_read_data
);

  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_POLL, S_WR_BLK, S_WR_CTRL, S_SETTLE, S_POLL, S_RD_DIG, S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [1:0]    phase_reg, phase_next;
  logic [3:0]    idx_reg, idx_next;
  logic [15:0]   timer_reg, timer_next;
  logic          error_reg, error_next;
  logic [639:0]  header_reg;
  logic [255:0]  mid_reg;
  logic [255:0]  hash_reg;
  logic [31:0]   hdr_word [20];
  logic [31:0]   mid_word [8];
  logic [31:0]   blk_word;
  logic          timed_out;
  logic          settle_last;

  genvar gi;
  generate
    for (gi = 0; gi < 20; gi++) begin : g_hdr_word
      assign hdr_word[gi] = header_reg[639 - 32*gi -: 32];
    end
    for (gi = 0; gi < 8; gi++) begin : g_mid_word
      assign mid_word[gi] = mid_reg[255 - 32*gi -: 32];
    end
  endgenerate

  assign timed_out   = (timer_reg == 16'(TIMEOUT_CYCLES - 1));
  assign settle_last = (idx_reg == 4'(SETTLE_CYCLES - 1));

  // Message block word for the current phase, padding included.
  always_comb begin
    blk_word = '0;
    case (phase_reg)
      2'd0: blk_word = hdr_word[{1'b0, idx_reg}];
      2'd1: begin
        if (idx_reg < 4'd4)       blk_word = hdr_word[{3'b100, idx_reg[1:0]}];
        else if (idx_reg == 4'd4) blk_word = 32'h8000_0000;
        else if (idx_reg == 4'd15) blk_word = 32'h0000_0280;
      end
      2'd2: begin
        if (idx_reg < 4'd8)       blk_word = mid_word[idx_reg[2:0]];
        else if (idx_reg == 4'd8) blk_word = 32'h8000_0000;
        else if (idx_reg == 4'd15) blk_word = 32'h0000_0100;
      end
      default: blk_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      phase_reg <= '0;
      idx_reg   <= '0;
      timer_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      idx_reg   <= idx_next;
      timer_reg <= timer_next;
      error_reg <= error_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    idx_next       = idx_reg;
    timer_next     = timer_reg;
    error_next     = 1'b0;
    sha_cs         = 1'b0;
    sha_we         = 1'b0;
    sha_address    = '0;
    sha_write_data = '0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_PRE_POLL;
          phase_next = 2'd0;
          idx_next   = '0;
          timer_next = '0;
        end
      end
      S_PRE_POLL: begin
        sha_cs      = 1'b1;
        sha_address = ADDR_STATUS;
        if (sha_read_data[0]) begin
          state_next = S_WR_BLK;
          idx_next   = '0;
        end else if (timed_out) begin
          state_next = S_IDLE;
          error_next = 1'b1;
        end else begin
          timer_next = timer_reg + 16'd1;
        end
      end
      S_WR_BLK: begin
        sha_cs         = 1'b1;
        sha_we         = 1'b1;
        sha_address    = {4'h1, idx_reg};
        sha_write_data = blk_word;
        idx_next       = idx_reg + 4'd1;
        if (idx_reg == 4'd15) state_next = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        sha_cs         = 1'b1;
        sha_we         = 1'b1;
        sha_address    = ADDR_CTRL;
        sha_write_data = (phase_reg == 2'd1) ? 32'h6 : 32'h5;
        state_next     = S_SETTLE;
        idx_next       = '0;
      end
      S_SETTLE: begin
        if (settle_last) begin
          state_next = S_POLL;
          idx_next   = '0;
          timer_next = '0;
        end else begin
          idx_next = idx_reg + 4'd1;
        end
      end
      S_POLL: begin
        sha_cs      = 1'b1;
        sha_address = ADDR_STATUS;
        if (sha_read_data[1:0] == 2'b11) begin
          idx_next = '0;
          if (phase_reg == 2'd0) begin
            state_next = S_WR_BLK;
            phase_next = 2'd1;
          end else begin
            state_next = S_RD_DIG;
          end
        end else if (timed_out) begin
          state_next = S_IDLE;
          error_next = 1'b1;
        end else begin
          timer_next = timer_reg + 16'd1;
        end
      end
      S_RD_DIG: begin
        sha_cs      = 1'b1;
        sha_address = {5'b00100, idx_reg[2:0]};
        idx_next    = idx_reg + 4'd1;
        if (idx_reg == 4'd7) begin
          idx_next = '0;
          if (phase_reg == 2'd1) begin
            state_next = S_WR_BLK;
            phase_next = 2'd2;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // mid_reg collects the phase-1 digest; in phase 2 it is reused as the capture
  // buffer so the final hash appears in one step together with done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      header_reg <= '0;
      mid_reg    <= '0;
      hash_reg   <= '0;
    end else begin
      if (state_reg == S_IDLE && start) header_reg <= header;
      if (state_reg == S_RD_DIG) begin
        for (int i = 0; i < 8; i++) begin
          if (idx_reg[2:0] == 3'(i)) mid_reg[255 - 32*i -: 32] <= sha_read_data;
        end
        if (phase_reg == 2'd2 && idx_reg == 4'd7) hash_reg <= {mid_reg[255:32], sha_read_data};
      end
    end
  end

  assign busy  = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done  = (state_reg == S_DONE);
  assign error = error_reg;
  assign hash  = hash_reg;

endmodule

// File: tb/tb_sha256d_header_ctrl.sv
// Bench for sha256d_header_ctrl: behavioural sha256 register slave, bus monitor,
// reference SHA-256d, table-driven jobs plus timeout / restart / reset corner sequences.
module tb_sha256d_header_ctrl;

  localparam int SLAVE_LAT = 6;
  // Start cycle is cycle 1; latency N = 1 + 1 + 3*(16+1+4+3) + 16 + 1 = 91 with
  // three poll cycles per phase. The wait loop starts in cycle 2, so done is seen at N-2.
  localparam int EXP_DONE_K = 89;

  logic         clk = 1'b0;
  logic         reset_n, start;
  logic [639:0] header;
  logic         busy, done, error;
  logic [255:0] hash;
  logic         sha_cs, sha_we;
  logic [7:0]   sha_address;
  logic [31:0]  sha_write_data, sha_read_data;

  always #5 clk = ~clk;

  sha256d_header_ctrl #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .header(header),
    .busy(busy), .done(done), .error(error), .hash(hash),
    .sha_cs(sha_cs), .sha_we(sha_we), .sha_address(sha_address),
    .sha_write_data(sha_write_data), .sha_read_data(sha_read_data)
  );

  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, hh} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k_tab[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + hh};
  endfunction

  function automatic logic [255:0] ref_sha256d(input logic [639:0] hdr);
    logic [255:0] d1;
    d1 = sha_compress(IV, hdr[639:128]);
    d1 = sha_compress(d1, {hdr[127:0], 32'h80000000, 320'h0, 32'h00000280});
    return sha_compress(IV, {d1, 32'h80000000, 192'h0, 32'h00000100});
  endfunction

  // Behavioural sha256 slave: status drops on a CTRL write, result after SLAVE_LAT edges.
  logic         slave_rst, stuck;
  logic [31:0]  blk [16];
  logic [511:0] blk_flat;
  logic [255:0] h_cur, h_pend;
  logic [1:0]   status;
  int           cnt;

  always_comb begin
    blk_flat = '0;
    for (int i = 0; i < 16; i++) blk_flat[511 - 32*i -: 32] = blk[i];
  end

  always @(posedge clk) begin
    if (slave_rst) begin
      status <= 2'b01;
      cnt    <= 0;
      h_cur  <= '0;
      h_pend <= '0;
    end else begin
      if (sha_cs && sha_we && sha_address[7:4] == 4'h1) blk[sha_address[3:0]] <= sha_write_data;
      if (sha_cs && sha_we && sha_address == 8'h08) begin
        status <= 2'b00;
        cnt    <= SLAVE_LAT;
        if (sha_write_data[0])      h_pend <= sha_compress(IV, blk_flat);
        else if (sha_write_data[1]) h_pend <= sha_compress(h_cur, blk_flat);
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          status <= 2'b11;
          h_cur  <= h_pend;
        end
      end
    end
  end

  always_comb begin
    sha_read_data = '0;
    if (sha_cs && !sha_we) begin
      if (sha_address == 8'h09) sha_read_data = stuck ? 32'h0 : {30'h0, status};
      else if (sha_address[7:3] == 5'b00100) sha_read_data = h_cur[255 - 32*int'(sha_address[2:0]) -: 32];
    end
  end

  // Bus monitor
  logic        mon_clear;
  int          ctrl_cnt, dig_reads, done_cnt, idle_bad;
  logic [31:0] ctrl_data [3];
  logic [31:0] p1 [16];
  logic [31:0] p2 [16];

  always @(posedge clk) begin
    if (mon_clear) begin
      ctrl_cnt  <= 0;
      dig_reads <= 0;
      done_cnt  <= 0;
    end else begin
      if (done) done_cnt <= done_cnt + 1;
      if (sha_cs && sha_we && sha_address == 8'h08) begin
        if (ctrl_cnt < 3) ctrl_data[ctrl_cnt] <= sha_write_data;
        ctrl_cnt <= ctrl_cnt + 1;
      end
      if (sha_cs && sha_we && sha_address[7:4] == 4'h1) begin
        if (ctrl_cnt == 1) p1[sha_address[3:0]] <= sha_write_data;
        if (ctrl_cnt == 2) p2[sha_address[3:0]] <= sha_write_data;
      end
      if (sha_cs && !sha_we && sha_address[7:4] == 4'h2) dig_reads <= dig_reads + 1;
    end
  end

  initial idle_bad = 0;
  always @(negedge clk)
    if (!sha_cs && (sha_we || sha_address != 8'h0 || sha_write_data != 32'h0)) idle_bad <= idle_bad + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic pulse_start(input logic [639:0] hdr);
    @(negedge clk);
    header = hdr;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic clear_mon();
    @(negedge clk);
    mon_clear = 1'b1;
    @(negedge clk);
    mon_clear = 1'b0;
  endtask

  task automatic wait_end(output int k, output bit got_done, output bit got_err);
    k = 0; got_done = 1'b0; got_err = 1'b0;
    while (!got_done && !got_err && k < 2000) begin
      @(negedge clk);
      k++;
      got_done = done;
      got_err  = error;
    end
  endtask

  typedef struct {
    logic [639:0] hdr;
    logic [255:0] exp;
  } vec_t;

  localparam logic [639:0] GENESIS = {32'h01000000, 256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
  localparam logic [255:0] GENESIS_HASH =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

  vec_t         vecs [3];
  logic [639:0] hdr_a, hdr_b, hdr_c;
  int           k, guard;
  bit           gd, ge, hit;

  initial begin
    vecs[0].hdr = GENESIS;
    vecs[0].exp = GENESIS_HASH;
    vecs[1].hdr = {8{80'h0123456789abcdef0011}};
    vecs[1].exp = ref_sha256d(vecs[1].hdr);
    vecs[2].hdr = {GENESIS[639:32], 32'h00000001};
    vecs[2].exp = ref_sha256d(vecs[2].hdr);
    hdr_a = {20{32'hcafef00d}};
    hdr_b = {20{32'h13572468}};
    hdr_c = {GENESIS[639:32], 32'hdeadbeef};

    reset_n = 1'b0; slave_rst = 1'b1; start = 1'b0; header = '0; stuck = 1'b0; mon_clear = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, done, error, sha_cs, sha_we, sha_address, sha_write_data}, '0);
    check("reset_hash", hash, '0);
    reset_n = 1'b1; slave_rst = 1'b0; mon_clear = 1'b0;

    // Timeout: STATUS stuck at 0
    stuck = 1'b1;
    pulse_start(GENESIS);
    wait_end(k, gd, ge);
    check("tmo_error", {ge, gd}, 2'b10);
    check("tmo_k", k, 8);
    check("tmo_busy", busy, 1'b0);
    check("tmo_hash", hash, '0);
    @(negedge clk);
    check("tmo_pulse", {error, done_cnt[3:0]}, 5'h0);
    stuck = 1'b0;

    for (int i = 0; i < 3; i++) begin
      clear_mon();
      pulse_start(vecs[i].hdr);
      wait_end(k, gd, ge);
      check($sformatf("v%0d_done", i), {gd, ge}, 2'b10);
      check($sformatf("v%0d_latency", i), k, EXP_DONE_K);
      check($sformatf("v%0d_hash", i), hash, vecs[i].exp);
      @(negedge clk);
      check($sformatf("v%0d_pulse", i), {done, busy, 30'(done_cnt)}, 32'h1);
      if (i == 0) begin
        check("bus_ctrl_n", ctrl_cnt, 3);
        check("bus_ctrl_seq", {ctrl_data[0], ctrl_data[1], ctrl_data[2]}, {32'h5, 32'h6, 32'h5});
        check("bus_p1_pad", {p1[4], p1[15]}, {32'h80000000, 32'h00000280});
        check("bus_p2_pad", {p2[8], p2[15]}, {32'h80000000, 32'h00000100});
        check("bus_dig_reads", dig_reads, 16);
      end
    end

    // Start mid-job ignored; next start one cycle after done accepted
    pulse_start(hdr_a);
    repeat (30) @(negedge clk);
    header = hdr_b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(k, gd, ge);
    check("midstart_done", gd, 1'b1);
    check("midstart_hash", hash, ref_sha256d(hdr_a));
    pulse_start(hdr_b);
    wait_end(k, gd, ge);
    check("restart_done", gd, 1'b1);
    check("restart_hash", hash, ref_sha256d(hdr_b));

    // Header changed the cycle after start
    @(negedge clk);
    header = hdr_c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; header = hdr_a;
    wait_end(k, gd, ge);
    check("latch_hash", hash, ref_sha256d(hdr_c));

    // Reset during phase-1 block write
    clear_mon();
    pulse_start(GENESIS);
    hit = 1'b0;
    guard = 0;
    while (!hit && guard < 500) begin
      @(negedge clk);
      guard++;
      hit = (ctrl_cnt == 1) && sha_cs && sha_we && (sha_address == 8'h12);
    end
    check("rst_reach_p1", hit, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_ctrl", {busy, done, error, sha_cs, sha_we, sha_address, sha_write_data}, '0);
    check("rst_hash", hash, '0);
    reset_n = 1'b1;
    pulse_start(GENESIS);
    wait_end(k, gd, ge);
    check("rst_job_done", gd, 1'b1);
    check("rst_job_hash", hash, GENESIS_HASH);

    check("idle_bus_zero", idle_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
